// File: rtl/rsa_mont_arbiter.sv
// Round-robin arbiter sharing one non-pipelined RSA exponentiation engine among N_REQ requesters.
// Optional perf counters (jobs_done, busy_cycles) are built when RSA_ARB_PERF_EN is defined.
module rsa_mont_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IN_W  = 1024,
  parameter int unsigned OUT_W = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        i_valid,
  output logic [N_REQ-1:0]        i_ready,
  input  logic [N_REQ*IN_W-1:0]   i_in,
  output logic [N_REQ-1:0]        o_valid,
  input  logic [N_REQ-1:0]        o_ready,
  output logic [OUT_W-1:0]        o_out,
  output logic                    m_i_valid,
  input  logic                    m_i_ready,
  output logic [IN_W-1:0]         m_i_in,
  input  logic                    m_o_valid,
  output logic                    m_o_ready,
  input  logic [OUT_W-1:0]        m_o_out
`ifdef RSA_ARB_PERF_EN
  ,
  output logic [31:0]             jobs_done,
  output logic [31:0]             busy_cycles
`endif
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SW = PW + 1;
  localparam logic [PW-1:0] LastIdx = PW'(N_REQ - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e             state_q;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      tag_q;
  logic [IN_W-1:0]    payload_q;
  logic [OUT_W-1:0]   result_q;
  logic               m_i_valid_q;
  logic               m_o_ready_q;
  logic [N_REQ-1:0]   o_valid_q;

  logic               grant_any;
  logic [PW-1:0]      grant_idx;
  logic [SW-1:0]      rr_sum;
  logic [N_REQ-1:0]   tag_onehot;

  // First valid requester at or after ptr_q, wrapping modulo N_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rr_sum = {1'b0, ptr_q} + SW'(i);
      if (rr_sum >= SW'(N_REQ)) rr_sum = rr_sum - SW'(N_REQ);
      if (!grant_any && i_valid[rr_sum[PW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = rr_sum[PW-1:0];
      end
    end
  end

  // Accept must coincide with the requester's valid, so i_ready is decoded, not registered.
  always_comb begin
    i_ready = '0;
    if (!rst && state_q == StIdle && grant_any) i_ready[grant_idx] = 1'b1;
  end

  assign tag_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      tag_q       <= '0;
      payload_q   <= '0;
      result_q    <= '0;
      m_i_valid_q <= 1'b0;
      m_o_ready_q <= 1'b0;
      o_valid_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_any) begin
            tag_q       <= grant_idx;
            payload_q   <= i_in[grant_idx*IN_W +: IN_W];
            m_i_valid_q <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (m_i_ready) begin
            m_i_valid_q <= 1'b0;
            m_o_ready_q <= 1'b1;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (m_o_valid) begin
            result_q    <= m_o_out;
            m_o_ready_q <= 1'b0;
            o_valid_q   <= tag_onehot;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (o_ready[tag_q]) begin
            o_valid_q <= '0;
            ptr_q     <= (tag_q == LastIdx) ? '0 : tag_q + PW'(1);
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_i_valid = m_i_valid_q;
  assign m_i_in    = payload_q;
  assign m_o_ready = m_o_ready_q;
  assign o_valid   = o_valid_q;
  assign o_out     = result_q;

`ifdef RSA_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      jobs_done   <= '0;
      busy_cycles <= '0;
    end else begin
      if (state_q != StIdle) busy_cycles <= busy_cycles + 32'd1;
      if (|(o_valid_q & o_ready)) jobs_done <= jobs_done + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rsa_mont_arbiter.sv
// Directed self-checking bench for rsa_mont_arbiter; the test bench drives the engine side by hand.
// Perf counter checks are compiled only when RSA_ARB_PERF_EN is defined.
module tb_rsa_mont_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 1024;
  localparam int unsigned OW = 256;

  logic            clk;
  logic            rst;
  logic [N-1:0]    i_valid;
  logic [N-1:0]    i_ready;
  logic [N*IW-1:0] i_in;
  logic [N-1:0]    o_valid;
  logic [N-1:0]    o_ready;
  logic [OW-1:0]   o_out;
  logic            m_i_valid;
  logic            m_i_ready;
  logic [IW-1:0]   m_i_in;
  logic            m_o_valid;
  logic            m_o_ready;
  logic [OW-1:0]   m_o_out;
`ifdef RSA_ARB_PERF_EN
  logic [31:0]     jobs_done;
  logic [31:0]     busy_cycles;
`endif

  int tests = 0;
  int fails = 0;

  rsa_mont_arbiter #(.N_REQ(N), .IN_W(IW), .OUT_W(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_in      (i_in),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_out     (o_out),
    .m_i_valid (m_i_valid),
    .m_i_ready (m_i_ready),
    .m_i_in    (m_i_in),
    .m_o_valid (m_o_valid),
    .m_o_ready (m_o_ready),
    .m_o_out   (m_o_out)
`ifdef RSA_ARB_PERF_EN
    ,
    .jobs_done   (jobs_done),
    .busy_cycles (busy_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (low 64 bits)", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [IW-1:0] payload(input int k);
    payload = {OW'(32'hB000 + k), OW'(32'hC000 + k), OW'(32'hD000 + k), OW'(32'hE000 + k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full job for requester k; caller has already raised i_valid with state idle.
  task automatic serve(input int k, input logic [OW-1:0] res, input int mi_stall, input int lat,
                       input int o_stall, input logic [N-1:0] after);
    logic [N-1:0] oh;
    oh = 4'b0001 << k;
    @(negedge clk);
    check("grant", IW'(i_ready), IW'(oh));
    tick();
    i_valid   = after;
    m_i_ready = 1'b0;
    for (int c = 0; c < mi_stall; c++) begin
      m_o_valid = 1'b1;
      m_o_out   = OW'(32'hBAD0);
      @(negedge clk);
      check("issue_hold_valid", IW'(m_i_valid), IW'(1));
      check("issue_hold_data", m_i_in, payload(k));
      check("issue_no_i_ready", IW'(i_ready), IW'(0));
      check("issue_no_m_o_ready", IW'(m_o_ready), IW'(0));
      tick();
    end
    m_o_valid = 1'b0;
    m_i_ready = 1'b1;
    @(negedge clk);
    check("issue_valid", IW'(m_i_valid), IW'(1));
    check("issue_data", m_i_in, payload(k));
    tick();
    m_i_ready = 1'b0;
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      check("wait_m_o_ready", IW'(m_o_ready), IW'(1));
      check("wait_no_reissue", IW'(m_i_valid), IW'(0));
      check("wait_no_o_valid", IW'(o_valid), IW'(0));
      tick();
    end
    m_o_valid = 1'b1;
    m_o_out   = res;
    @(negedge clk);
    check("capture_m_o_ready", IW'(m_o_ready), IW'(1));
    tick();
    m_o_valid = 1'b0;
    m_o_out   = '0;
    o_ready   = ~oh;
    for (int c = 0; c < o_stall; c++) begin
      @(negedge clk);
      check("resp_hold_valid", IW'(o_valid), IW'(oh));
      check("resp_hold_data", IW'(o_out), IW'(res));
      check("resp_no_i_ready", IW'(i_ready), IW'(0));
      tick();
    end
    o_ready = 4'b1111;
    @(negedge clk);
    check("resp_valid", IW'(o_valid), IW'(oh));
    check("resp_data", IW'(o_out), IW'(res));
    tick();
    o_ready = '0;
  endtask

  initial begin
    rst       = 1'b1;
    i_valid   = 4'b1111;
    o_ready   = '0;
    m_i_ready = 1'b0;
    m_o_valid = 1'b0;
    m_o_out   = '0;
    for (int k = 0; k < int'(N); k++) i_in[k*IW +: IW] = payload(k);

    // Reset: nothing asserted even with every requester valid.
    tick();
    tick();
    @(negedge clk);
    check("rst_i_ready", IW'(i_ready), IW'(0));
    check("rst_o_valid", IW'(o_valid), IW'(0));
    check("rst_m_i_valid", IW'(m_i_valid), IW'(0));
    check("rst_m_o_ready", IW'(m_o_ready), IW'(0));
    check("rst_m_i_in", m_i_in, IW'(0));
    check("rst_o_out", IW'(o_out), IW'(0));
    rst     = 1'b0;
    i_valid = '0;
    tick();

    // Single request from requester 0.
    i_valid = 4'b0001;
    serve(0, OW'(32'h1234), 0, 9, 0, 4'b0000);
    @(negedge clk);
    check("single_no_dup", IW'(m_i_valid), IW'(0));
    check("single_idle_ready", IW'(i_ready), IW'(0));
    tick();

    // Lone requester below ptr (ptr=1) still wins.
    i_valid = 4'b0001;
    serve(0, OW'(32'h5678), 1, 2, 1, 4'b0000);

    // Contention from reset: order 0,1,2,3, then wrap with 1001 -> 0 then 3.
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    i_valid = 4'b1111;
    serve(0, OW'(32'hA000), 0, 1, 0, 4'b1111);
    serve(1, OW'(32'hA001), 1, 0, 2, 4'b1111);
    serve(2, OW'(32'hA002), 0, 3, 1, 4'b1111);
    serve(3, OW'(32'hA003), 2, 1, 0, 4'b1001);
    serve(0, OW'(32'hA004), 0, 1, 0, 4'b1000);
    serve(3, OW'(32'hA005), 0, 1, 0, 4'b0000);

    // Back-pressure on both sides with requester 2 holding valid throughout.
    i_valid = 4'b0100;
    serve(2, OW'(32'hCAFE), 5, 3, 7, 4'b0100);
    i_valid = '0;
    @(negedge clk);
    check("bp_single_pulse", IW'(i_ready), IW'(0));
    check("bp_no_dup_issue", IW'(m_i_valid), IW'(0));
    tick();

    // Reset while waiting on the engine for requester 1 (ptr=3 beforehand).
    i_valid = 4'b0010;
    @(negedge clk);
    check("midrst_grant", IW'(i_ready), IW'(4'b0010));
    tick();
    i_valid   = '0;
    m_i_ready = 1'b1;
    @(negedge clk);
    check("midrst_issue", IW'(m_i_valid), IW'(1));
    tick();
    m_i_ready = 1'b0;
    @(negedge clk);
    check("midrst_wait", IW'(m_o_ready), IW'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_i_ready", IW'(i_ready), IW'(0));
    check("midrst_o_valid", IW'(o_valid), IW'(0));
    check("midrst_m_i_valid", IW'(m_i_valid), IW'(0));
    check("midrst_m_o_ready", IW'(m_o_ready), IW'(0));
    check("midrst_m_i_in", m_i_in, IW'(0));
    check("midrst_o_out", IW'(o_out), IW'(0));
    tick();
    m_o_valid = 1'b1;
    m_o_out   = OW'(32'hDEAD);
    @(negedge clk);
    check("late_m_o_ready", IW'(m_o_ready), IW'(0));
    tick();
    m_o_valid = 1'b0;
    @(negedge clk);
    check("late_no_o_valid", IW'(o_valid), IW'(0));
    check("late_o_out", IW'(o_out), IW'(0));
    tick();
    i_valid = 4'b1111;
    @(negedge clk);
    check("midrst_ptr_zero", IW'(i_ready), IW'(4'b0001));
    i_valid = '0;
    tick();

`ifdef RSA_ARB_PERF_EN
    check("perf_jobs_rst", IW'(jobs_done), IW'(0));
    check("perf_busy_rst", IW'(busy_cycles), IW'(0));
    for (int j = 0; j < 3; j++) begin
      i_valid = 4'b0001;
      serve(0, OW'(32'hF000 + j), 5, 7, 5, 4'b0000);
    end
    @(negedge clk);
    check("perf_jobs_done", IW'(jobs_done), IW'(3));
    check("perf_busy_cycles", IW'(busy_cycles), IW'(60));
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
